// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one registered-read memory port
// between instruction fetch and data access.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wd,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  output logic                  busy,
  output logic                  grant
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]            state;
  logic                  last_grant;
  logic                  tx_we;
  logic                  pick_d;
  logic                  resp;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;

  // Data wins when alone, or on conflict when fetch was served last.
  always_comb begin
    pick_d = d_req & (~if_req | ~last_grant);
  end

  // Sequencer: latch winner in IDLE, strobe memory, then respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      tx_we      <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wd     <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (if_req | d_req) begin
            state      <= ISSUE;
            last_grant <= pick_d;
            mem_en     <= 1'b1;
            mem_we     <= pick_d & d_we;
            tx_we      <= pick_d & d_we;
            mem_addr   <= pick_d ? d_addr : if_addr;
            if (pick_d) mem_wd <= d_wd;
          end
        end
        ISSUE: begin
          state  <= RESP;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
        RESP: begin
          state <= IDLE;
          if (!last_grant) if_rdata_q <= mem_rd;
          else if (!tx_we) d_rdata_q <= mem_rd;
        end
        default: begin
          state  <= IDLE;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Acks and read data: live memory data in RESP, held value otherwise.
  always_comb begin
    resp     = (state == RESP);
    busy     = (state != IDLE);
    grant    = last_grant;
    if_ack   = resp & ~last_grant;
    d_ack    = resp & last_grant;
    if_rdata = if_ack ? mem_rd : if_rdata_q;
    d_rdata  = (d_ack & ~tx_we) ? mem_rd : d_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a
// registered-read memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wd;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        busy;
  logic        grant;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .busy(busy), .grant(grant)
  );

  // Memory model: write or registered read on mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wd;
      else mem_rd <= mem[mem_addr[7:0]];
    end
  end

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        busy;
    logic        grant;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic        wd_chk;
    logic [31:0] wd;
    logic        iack;
    logic        dack;
    logic [31:0] ird;
    logic [31:0] drd;
  } vec_t;

  vec_t tv [15];

  localparam logic [31:0] FW = 32'h00A00093;
  localparam logic [31:0] BF = 32'hDEADBEEF;

  function automatic vec_t mk(
    logic ir, logic [31:0] ia, logic dr, logic dw,
    logic [31:0] da, logic [31:0] dwd,
    logic b, logic g, logic en, logic we,
    logic [31:0] addr, logic wc, logic [31:0] wd,
    logic ik, logic dk, logic [31:0] ird, logic [31:0] drd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw;
    v.da = da; v.dwd = dwd;
    v.busy = b; v.grant = g; v.en = en; v.we = we;
    v.addr = addr; v.wd_chk = wc; v.wd = wd;
    v.iack = ik; v.dack = dk; v.ird = ird; v.drd = drd;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic ir, logic [31:0] ia, logic dr,
                       logic dw, logic [31:0] da, logic [31:0] dwd);
    if_req = ir; if_addr = ia;
    d_req = dr; d_we = dw; d_addr = da; d_wd = dwd;
  endtask

  logic [31:0] fa [4];
  logic [31:0] fd [4];
  int          k;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h14] = FW;
    fa[0] = 32'h20; fd[0] = 32'h11111111;
    fa[1] = 32'h24; fd[1] = 32'h22222222;
    fa[2] = 32'h28; fd[2] = 32'h33333333;
    fa[3] = 32'h2C; fd[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) mem[fa[i][7:0]] = fd[i];
    mem_rd = 32'h0;

    //     ir ia    dr dw da    dwd   b  g  en we addr  wc wd   ik dk ird drd
    tv[0]  = mk(1, 32'h14, 0, 0, 0, 0,  1, 0, 1, 0, 32'h14, 1, 0,  0, 0, 0,  0);
    tv[1]  = mk(1, 32'h14, 0, 0, 0, 0,  1, 0, 0, 0, 32'h14, 1, 0,  1, 0, FW, 0);
    tv[2]  = mk(1, 32'h14, 0, 0, 0, 0,  0, 0, 0, 0, 32'h14, 1, 0,  0, 0, FW, 0);
    tv[3]  = mk(0, 0, 1, 1, 32'h35, BF, 1, 1, 1, 1, 32'h35, 1, BF, 0, 0, FW, 0);
    tv[4]  = mk(0, 0, 1, 1, 32'h35, BF, 1, 1, 0, 0, 32'h35, 1, BF, 0, 1, FW, 0);
    tv[5]  = mk(0, 0, 1, 1, 32'h35, BF, 0, 1, 0, 0, 32'h35, 1, BF, 0, 0, FW, 0);
    tv[6]  = mk(0, 0, 1, 0, 32'h35, BF, 1, 1, 1, 0, 32'h35, 0, 0,  0, 0, FW, 0);
    tv[7]  = mk(0, 0, 1, 0, 32'h35, BF, 1, 1, 0, 0, 32'h35, 0, 0,  0, 1, FW, BF);
    tv[8]  = mk(0, 0, 1, 0, 32'h35, BF, 0, 1, 0, 0, 32'h35, 0, 0,  0, 0, FW, BF);
    tv[9]  = mk(1, 32'h14, 1, 0, 32'h35, BF, 1, 0, 1, 0, 32'h14, 0, 0, 0, 0, FW, BF);
    tv[10] = mk(1, 32'h14, 1, 0, 32'h35, BF, 1, 0, 0, 0, 32'h14, 0, 0, 1, 0, FW, BF);
    tv[11] = mk(1, 32'h14, 1, 0, 32'h35, BF, 0, 0, 0, 0, 32'h14, 0, 0, 0, 0, FW, BF);
    tv[12] = mk(0, 32'h14, 1, 0, 32'h35, BF, 1, 1, 1, 0, 32'h35, 0, 0, 0, 0, FW, BF);
    tv[13] = mk(0, 32'h14, 1, 0, 32'h35, BF, 1, 1, 0, 0, 32'h35, 0, 0, 0, 1, FW, BF);
    tv[14] = mk(0, 32'h14, 1, 0, 32'h35, BF, 0, 1, 0, 0, 32'h35, 0, 0, 0, 0, FW, BF);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.busy", {31'b0, busy}, 0);
    chk("rst.grant", {31'b0, grant}, 0);
    chk("rst.en_we", {30'b0, mem_en, mem_we}, 0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.wd", mem_wd, 0);
    chk("rst.acks", {30'b0, if_ack, d_ack}, 0);
    chk("rst.ird", if_rdata, 0);
    chk("rst.drd", d_rdata, 0);

    for (int i = 0; i < 15; i++) begin
      drive(tv[i].ir, tv[i].ia, tv[i].dr, tv[i].dw, tv[i].da, tv[i].dwd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.busy", i), {31'b0, busy}, {31'b0, tv[i].busy});
      chk($sformatf("v%0d.grant", i), {31'b0, grant}, {31'b0, tv[i].grant});
      chk($sformatf("v%0d.en", i), {31'b0, mem_en}, {31'b0, tv[i].en});
      chk($sformatf("v%0d.we", i), {31'b0, mem_we}, {31'b0, tv[i].we});
      chk($sformatf("v%0d.addr", i), mem_addr, tv[i].addr);
      if (tv[i].wd_chk) chk($sformatf("v%0d.wd", i), mem_wd, tv[i].wd);
      chk($sformatf("v%0d.iack", i), {31'b0, if_ack}, {31'b0, tv[i].iack});
      chk($sformatf("v%0d.dack", i), {31'b0, d_ack}, {31'b0, tv[i].dack});
      chk($sformatf("v%0d.ird", i), if_rdata, tv[i].ird);
      chk($sformatf("v%0d.drd", i), d_rdata, tv[i].drd);
    end

    // Reset in the middle of a write's ISSUE cycle.
    drive(0, 0, 1, 1, 32'h50, 32'h12345678);
    @(posedge clk);
    #1;
    chk("arst.pre_en_we", {30'b0, mem_en, mem_we}, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.en_we", {30'b0, mem_en, mem_we}, 0);
    chk("arst.busy", {31'b0, busy}, 0);
    chk("arst.dack", {31'b0, d_ack}, 0);
    chk("arst.addr_wd", mem_addr | mem_wd, 0);
    chk("arst.drd", d_rdata, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("arst.hold_dack", {31'b0, d_ack}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst.post_busy", {31'b0, busy}, 0);
    chk("arst.post_outs",
        {26'b0, grant, mem_en, mem_we, if_ack, d_ack, 1'b0}, 0);
    chk("arst.post_rdata", if_rdata | d_rdata | mem_addr, 0);

    // Both ports held: data first, then strict alternation.
    drive(1, 32'h20, 1, 0, 32'h24, 0);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d.dack", c), {31'b0, d_ack},
          {31'b0, (c % 6) == 2});
      chk($sformatf("rr%0d.iack", c), {31'b0, if_ack},
          {31'b0, (c % 6) == 5});
      if ((c % 3) == 1)
        chk($sformatf("rr%0d.grant", c), {31'b0, grant},
            {31'b0, (c % 6) == 1});
      if ((c % 6) == 2) chk($sformatf("rr%0d.drd", c), d_rdata, fd[1]);
      if ((c % 6) == 5) chk($sformatf("rr%0d.ird", c), if_rdata, fd[0]);
    end
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("rr.idle", {31'b0, busy}, 0);

    // Back-to-back fetches with a new address after each ack.
    k = 0;
    drive(1, fa[0], 0, 0, 0, 0);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bb%0d.iack", c), {31'b0, if_ack},
          {31'b0, (c % 3) == 2});
      chk($sformatf("bb%0d.dack", c), {31'b0, d_ack}, 0);
      if ((c % 3) == 1)
        chk($sformatf("bb%0d.addr", c), mem_addr, fa[k]);
      if ((c % 3) == 2)
        chk($sformatf("bb%0d.ird", c), if_rdata, fd[k]);
      if ((c % 3) == 0 && k < 3) begin
        k++;
        if_addr = fa[k];
      end
    end
    drive(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified instruction/data memory between the core's instruction-fetch port and its data port, which is the RAM/stack path leaving the memory-map decoder. The arbiter sequences each access through a fixed three-state handshake and drives the memory's registered-read interface. It resolves simultaneous requests round-robin and returns read data with a one-cycle acknowledge to the winning requester. It sits between the core and the RAM instance, downstream of the address decode.

## Interface
- DATA_WIDTH, 32, width of read/write data
- ADDR_WIDTH, 32, width of word addresses (already translated by the memory map)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held high until if_ack
- if_addr  in  ADDR_WIDTH  fetch word address; stable while if_req high
- if_ack  out  1  one-cycle pulse; if_rdata valid this cycle
- if_rdata  out  DATA_WIDTH  fetched word
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  1 = write, 0 = read; stable while d_req high
- d_addr  in  ADDR_WIDTH  data word address
- d_wd  in  DATA_WIDTH  write data
- d_ack  out  1  one-cycle pulse; d_rdata valid this cycle (reads)
- d_rdata  out  DATA_WIDTH  loaded word
- mem_en  out  1  memory access strobe (registered)
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  ADDR_WIDTH  memory word address (registered)
- mem_wd  out  DATA_WIDTH  memory write data (registered)
- mem_rd  in  DATA_WIDTH  memory read data, valid the cycle after mem_en
- busy  out  1  high in ISSUE and RESP
- grant  out  1  owner of the current transaction: 0 = fetch, 1 = data

## Operation
- States: IDLE, ISSUE, RESP. The reset state is IDLE.
- **IDLE**
  - With no request, stay in IDLE.
  - With any request, select a winner, latch its address, data and we into mem_addr, mem_wd and mem_we, set mem_en, update grant, and go to ISSUE.
  - A fetch always latches mem_we = 0.
- **Arbitration**
  - A single requester wins immediately.
  - When both requesters are active, the one that was not granted most recently wins.
  - The last_grant register resets to 0 (fetch), so the first conflict after reset goes to data.
  - last_grant updates on every grant, including uncontested ones.
- **ISSUE**
  - mem_en = 1 and mem_we = latched value; the memory performs the access at the end of this cycle.
  - Next state is RESP unconditionally.
- **RESP**
  - mem_en = 0 and mem_we = 0.
  - Pulse the granted port's ack.
  - The granted port's rdata is driven from mem_rd and also registered, so it holds until that port's next ack.
  - Write transactions also ack in RESP; d_rdata is unchanged on a write ack.
  - Requests are ignored in RESP. Next state is IDLE.
- The non-granted ack stays 0 at all times. Acks are never asserted outside RESP.
- A requester deasserts req, or presents a new request, in the cycle after its ack. The arbiter re-samples only in IDLE, so a req still high in RESP is never double-served.
- A fetch request that arrives during a data transaction waits in IDLE and is served next, and vice versa. Neither port can starve.

## Timing
- Request sampled in IDLE at cycle T → ISSUE at T+1 (mem_en high) → RESP at T+2 (ack high, rdata valid) → IDLE at T+3.
- Latency is 2 cycles from sample to ack. Peak throughput is one access per 3 cycles.
- Reset values: state IDLE, last_grant 0, grant 0, busy 0, mem_en 0, mem_we 0, mem_addr 0, mem_wd 0, if_ack 0, d_ack 0, if_rdata 0, d_rdata 0.
- Reset asserted mid-transaction (ISSUE or RESP):
  - All outputs go to their reset values immediately, asynchronously.
  - No ack is issued, and a pending write is not guaranteed to complete. The requester re-issues after reset.
- mem_addr and mem_wd hold their last values in IDLE and RESP. Only mem_en and mem_we qualify them.
- No address arithmetic is performed: addresses pass through unmodified at ADDR_WIDTH.

## Test plan
- **Reset values**: assert rst_n=0 mid-ISSUE of a d_we=1 request → mem_en=0 and mem_we=0 within the same cycle, no d_ack; after release, state is IDLE and all outputs are 0.
- **Lone fetch**: if_req=1, if_addr=0x14, memory returns 0x00A00093 → mem_en=1 with mem_addr=0x14 and mem_we=0 at T+1; if_ack=1 with if_rdata=0x00A00093 at T+2; d_ack=0 throughout.
- **Data write then read**: d_we=1, d_addr=0x35, d_wd=0xDEADBEEF → mem_we=1 at T+1 and d_ack at T+2. A following read of 0x35 → d_rdata=0xDEADBEEF on its d_ack, 3 cycles after the first ack.
- **Simultaneous requests after reset**: if_req=d_req=1 held → order of acks is d, if, d, if… Each ack is spaced 3 cycles apart, and grant toggles per transaction.
- **No double-service**: d_req held one extra cycle past d_ack (into IDLE) with if_req=1 → fetch is granted, since data was the most recent grant; the data request is served after it.
- **Back-to-back fetches**: if_req continuously high for 4 requests with changing if_addr → 4 if_acks at cycles T+2, T+5, T+8 and T+11, with rdata matching each address.
